fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared NOP encoding, fetch FSM states and FIFO entry layout (HALT exists only with FETCH_MISALIGN_CHECK_EN)
package fetch_unit_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int FETCH_STATE_WIDTH = 2;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {FETCH_BOOT, FETCH_RUN, FETCH_FLUSH, FETCH_HALT} fetch_state_t;
`else
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {FETCH_BOOT, FETCH_RUN, FETCH_FLUSH} fetch_state_t;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer; clear beats push/pop, push into a full FIFO needs a same-cycle pop
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + credit-limited imem requests + instruction buffer with redirect flush and stale-response dropping
// Optional FETCH_MISALIGN_CHECK_EN adds o_fetch_err and a HALT state on misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_redirect,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  logic [31:0] i_redirect_pc,
    output logic        o_fetch_err
`else
    input  logic [31:0] i_redirect_pc
`endif
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] live;
    logic [OW-1:0] out_next;
    logic [OW-1:0] drop_next;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    logic [31:0]   target;
    logic          redir;
    logic          can_fetch;
    logic          req_hs;
    logic          rsp_drop;
    logic          push;
    logic          pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;
    assign redir     = i_redirect && state != FETCH_HALT;
    assign misalign  = redir && i_redirect_pc[1:0] != 2'b00;
    assign can_fetch = state != FETCH_BOOT && state != FETCH_HALT;
    assign target    = i_redirect_pc;
`else
    assign redir     = i_redirect;
    assign can_fetch = state != FETCH_BOOT;
    assign target    = i_redirect_pc & ~32'h3;
`endif

    // responses still owed to the current path; each one already has a reserved FIFO slot
    assign live             = outstanding - drop_cnt;
    assign o_imem_req_valid = can_fetch && !i_redirect && outstanding < OW'(MAX_OUTSTANDING)
                              && (int'(fifo_count) + int'(live)) < FIFO_DEPTH;
    assign o_imem_addr      = pc;
    assign req_hs           = o_imem_req_valid && i_imem_req_ready;
    assign rsp_drop         = i_imem_rsp_valid && drop_cnt != '0;
    assign push             = i_imem_rsp_valid && drop_cnt == '0 && !redir;
    assign pop              = o_instr_valid && i_instr_ready;
    assign out_next         = outstanding + OW'(req_hs) - OW'(i_imem_rsp_valid);
    assign drop_next        = redir ? outstanding - OW'(i_imem_rsp_valid) : drop_cnt - OW'(rsp_drop);

    assign o_instr_valid = !fifo_empty;
    assign o_instr       = fifo_empty ? NOP : head.instr;
    assign o_instr_pc    = fifo_empty ? '0 : head.pc;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .clear (redir),
        .wdata ('{pc: resp_pc, instr: i_imem_rsp_data}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= FETCH_BOOT;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            o_fetch_err <= 1'b0;
`endif
        end else begin
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            if (redir) begin
                pc      <= target;
                resp_pc <= target;
`ifdef FETCH_MISALIGN_CHECK_EN
                state       <= misalign ? FETCH_HALT : drop_next != '0 ? FETCH_FLUSH : FETCH_RUN;
                o_fetch_err <= o_fetch_err || misalign;
`else
                state   <= drop_next != '0 ? FETCH_FLUSH : FETCH_RUN;
`endif
            end else begin
                pc      <= pc + 32'(req_hs) * 32'd4;
                resp_pc <= resp_pc + 32'(push) * 32'd4;
                state   <= state == FETCH_BOOT ? FETCH_RUN
                         : (state == FETCH_FLUSH && drop_next == '0) ? FETCH_RUN : state;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (outstanding <= OW'(MAX_OUTSTANDING) && drop_cnt <= outstanding)
                else $error("fetch_unit: outstanding/drop counter invariant broken");
            assert (!(push && fifo_full && !pop))
                else $error("fetch_unit: response arrived with no reserved FIFO slot");
        end
    end
`endif

endmodule
